// File: rtl/sdram_porta_arbiter.sv
// SDRAM port A arbiter: queues loader byte writes, issues one per NES slot, then hands port A to the CPU.
// Optional ARB_WRITE_COUNT_EN adds o_wr_count, the number of loader writes launched since LOAD entry.
module sdram_porta_arbiter #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SLOT_PHASE  = 3,
    parameter int unsigned HOLD_CYCLES = 255
) (
    input  logic              clock,
    input  logic              R_reset,
    input  logic [1:0]        i_nes_ce,
    input  logic              i_ld_valid,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [7:0]        i_ld_data,
    output logic              o_ld_ready,
    input  logic              i_ld_done,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_we,
    input  logic              i_cpu_oe,
    input  logic [7:0]        i_cpu_dout,
    output logic [ADDR_W+2:0] o_mem_addr,
    output logic              o_mem_we,
    output logic              o_mem_oe,
    output logic [7:0]        o_mem_din,
    output logic              o_nes_reset,
    output logic              o_overflow,
    output logic              o_busy
`ifdef ARB_WRITE_COUNT_EN
    ,
    output logic [ADDR_W:0]   o_wr_count
`endif
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + 8;
    localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t              r_state;
    logic [ENTRY_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_wr_we;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;
    logic                r_overflow;
    logic [7:0]          r_hold;
    logic                r_ld_done_q;
`ifdef ARB_WRITE_COUNT_EN
    logic [ADDR_W:0]     r_wr_count;
`endif

    logic w_ld_fall;
    logic w_full;
    logic w_empty;
    logic w_slot;
    logic w_launch;
    logic w_push;
    logic w_pop;
    logic w_run;

    assign w_ld_fall = r_ld_done_q & ~i_ld_done;
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_slot    = (i_nes_ce == 2'(SLOT_PHASE));
    assign w_launch  = w_slot & ((r_state == S_LOAD) | (r_state == S_DRAIN));
    assign w_push    = (r_state == S_LOAD) & i_ld_valid & ~w_full;
    assign w_pop     = w_launch & ~w_empty;
    assign w_run     = (r_state == S_RUN);

    // Loader write FIFO storage; pointers live in the control block below
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {i_ld_addr, i_ld_data};
        end
    end

    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_state     <= S_LOAD;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_we     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_overflow  <= 1'b0;
            r_hold      <= HOLD_INIT;
            r_ld_done_q <= 1'b1;
`ifdef ARB_WRITE_COUNT_EN
            r_wr_count  <= '0;
`endif
        end else begin
            r_ld_done_q <= i_ld_done;
            // A full FIFO drops the byte even when a pop frees a slot this cycle
            if (i_ld_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_ld_fall) begin
                r_state   <= S_LOAD;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_wr_we   <= 1'b0;
                r_wr_addr <= '0;
                r_wr_data <= '0;
                r_hold    <= HOLD_INIT;
`ifdef ARB_WRITE_COUNT_EN
                r_wr_count <= '0;
`endif
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
                // Write register holds for a whole nes_ce period, until the next slot
                if (w_launch) begin
                    r_wr_we <= ~w_empty;
                    if (!w_empty) begin
                        {r_wr_addr, r_wr_data} <= r_fifo[r_rd_ptr];
                    end
                end
`ifdef ARB_WRITE_COUNT_EN
                if (w_pop && (r_wr_count != '1)) begin
                    r_wr_count <= r_wr_count + (ADDR_W+1)'(1);
                end
`endif
                case (r_state)
                    S_LOAD: begin
                        if (i_ld_done) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        // Leave on the edge that retires the last write
                        if (w_empty && (!r_wr_we || w_slot)) begin
                            r_state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        r_hold <= r_hold - 8'd1;
                        if (r_hold == 8'd1) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // CPU owns the port combinationally once running
    assign o_mem_addr  = w_run ? {3'b000, i_cpu_addr} : {3'b000, r_wr_addr};
    assign o_mem_we    = w_run ? i_cpu_we   : r_wr_we;
    assign o_mem_din   = w_run ? i_cpu_dout : r_wr_data;
    assign o_mem_oe    = w_run & i_cpu_oe;
    assign o_nes_reset = ~w_run;
    assign o_busy      = ~w_run;
    assign o_ld_ready  = ~w_full;
    assign o_overflow  = r_overflow;
`ifdef ARB_WRITE_COUNT_EN
    assign o_wr_count  = r_wr_count;
`endif

endmodule

// File: tb/tb_sdram_porta_arbiter.sv
// Bench for sdram_porta_arbiter: queue-based reference model checked every clock, a RUN mux vector table,
// directed sequences for latency, overflow, drain/hold-off, re-download and reset, then random traffic.
module tb_sdram_porta_arbiter;

    localparam int DEPTH = 4;
    localparam int HOLD  = 255;
    localparam int M_LOAD = 0, M_DRAIN = 1, M_HOLD = 2, M_RUN = 3;

    logic        clock = 1'b0;
    logic        R_reset = 1'b1;
    logic [1:0]  nes_ce = 2'd0;
    logic        ld_valid = 1'b0;
    logic [21:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready;
    logic        ld_done = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_oe = 1'b0;
    logic [7:0]  cpu_dout = '0;
    logic [24:0] mem_addr;
    logic        mem_we;
    logic        mem_oe;
    logic [7:0]  mem_din;
    logic        nes_reset;
    logic        overflow;
    logic        busy;
`ifdef ARB_WRITE_COUNT_EN
    logic [22:0] wr_count;
`endif

    sdram_porta_arbiter dut (
        .clock      (clock),
        .R_reset    (R_reset),
        .i_nes_ce   (nes_ce),
        .i_ld_valid (ld_valid),
        .i_ld_addr  (ld_addr),
        .i_ld_data  (ld_data),
        .o_ld_ready (ld_ready),
        .i_ld_done  (ld_done),
        .i_cpu_addr (cpu_addr),
        .i_cpu_we   (cpu_we),
        .i_cpu_oe   (cpu_oe),
        .i_cpu_dout (cpu_dout),
        .o_mem_addr (mem_addr),
        .o_mem_we   (mem_we),
        .o_mem_oe   (mem_oe),
        .o_mem_din  (mem_din),
        .o_nes_reset(nes_reset),
        .o_overflow (overflow),
        .o_busy     (busy)
`ifdef ARB_WRITE_COUNT_EN
        ,
        .o_wr_count (wr_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the pending bytes are a queue, the active write is a record
    logic [29:0] q[$];
    int          m_mode;
    logic        m_we;
    logic [21:0] m_addr;
    logic [7:0]  m_data;
    int          m_hold;
    logic        m_ovf;
    logic        m_prev;
    int          m_cnt;
    logic [1:0]  last_ce;

    typedef struct {
        logic [21:0] addr;
        logic        we;
        logic        oe;
        logic [7:0]  dout;
        logic [24:0] e_addr;
        logic        e_we;
        logic        e_oe;
        logic [7:0]  e_din;
    } mux_vec_t;
    mux_vec_t tv [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_mode = M_LOAD;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_hold = HOLD;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        logic fall, full, was_empty, old_we, slot;
        int   old_mode;
        logic [29:0] e;
        if (R_reset) begin
            model_clear();
            m_ovf  = 1'b0;
            m_prev = 1'b1;
            return;
        end
        fall   = m_prev && !ld_done;
        m_prev = ld_done;
        full   = (q.size() == DEPTH);
        if (ld_valid && full) m_ovf = 1'b1;
        if (fall) begin
            model_clear();
            return;
        end
        old_mode  = m_mode;
        old_we    = m_we;
        was_empty = (q.size() == 0);
        slot      = (nes_ce == 2'd3);
        if (slot && (old_mode == M_LOAD || old_mode == M_DRAIN)) begin
            if (!was_empty) begin
                e = q.pop_front();
                m_addr = e[29:8];
                m_data = e[7:0];
                m_we   = 1'b1;
                if (m_cnt < 32'h7FFFFF) m_cnt++;
            end else begin
                m_we = 1'b0;
            end
        end
        if (old_mode == M_LOAD && ld_valid && !full) q.push_back({ld_addr, ld_data});
        case (old_mode)
            M_LOAD:  if (ld_done) m_mode = M_DRAIN;
            M_DRAIN: if (was_empty && (!old_we || slot)) begin
                m_mode = M_HOLD;
                m_hold = HOLD;
            end
            M_HOLD: begin
                m_hold--;
                if (m_hold == 0) m_mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        logic run;
        run = (m_mode == M_RUN);
        chk("model mem_addr",  32'(mem_addr),  run ? 32'(cpu_addr) : 32'(m_addr));
        chk("model mem_we",    32'(mem_we),    32'(run ? cpu_we : m_we));
        chk("model mem_oe",    32'(mem_oe),    32'(run & cpu_oe));
        chk("model mem_din",   32'(mem_din),   run ? 32'(cpu_dout) : 32'(m_data));
        chk("model ld_ready",  32'(ld_ready),  32'(q.size() < DEPTH));
        chk("model nes_reset", 32'(nes_reset), 32'(!run));
        chk("model busy",      32'(busy),      32'(!run));
        chk("model overflow",  32'(overflow),  32'(m_ovf));
`ifdef ARB_WRITE_COUNT_EN
        chk("model wr_count",  32'(wr_count),  32'(m_cnt));
`endif
    endtask

    task automatic tick();
        model_step();
        last_ce = nes_ce;
        @(posedge clock);
        #1;
        nes_ce = nes_ce + 2'd1;
        check_model();
    endtask

    task automatic align(input logic [1:0] ce);
        for (int k = 0; k < 4 && nes_ce != ce; k++) tick();
    endtask

    initial begin
        int first, nhigh, nw, t_fall, t_rst, seen;
        logic prev_we;
        logic [21:0] got_addr [8];
        logic [7:0]  got_data [8];

        tv[0] = '{22'h000000, 1'b0, 1'b1, 8'h00, 25'h0000000, 1'b0, 1'b1, 8'h00};
        tv[1] = '{22'h3FFFFF, 1'b1, 1'b0, 8'hFF, 25'h03FFFFF, 1'b1, 1'b0, 8'hFF};
        tv[2] = '{22'h2AAAAA, 1'b1, 1'b1, 8'h5A, 25'h02AAAAA, 1'b1, 1'b1, 8'h5A};
        tv[3] = '{22'h155555, 1'b0, 1'b0, 8'hA5, 25'h0155555, 1'b0, 1'b0, 8'hA5};

        // Reset with a download pending
        R_reset = 1'b1;
        tick();
        tick();
        R_reset = 1'b0;
        tick();
        tick();
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset nes_reset", 32'(nes_reset), 32'd1);
        chk("reset ld_ready", 32'(ld_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd1);
        chk("reset overflow", 32'(overflow), 32'd0);

        // Single push at nes_ce==1: write rises two clocks later and lasts one period
        align(2'd1);
        ld_valid = 1'b1; ld_addr = 22'h000010; ld_data = 8'hA5;
        tick();
        ld_valid = 1'b0;
        first = -1; nhigh = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (mem_we) begin
                if (first < 0) begin
                    first = k;
                    chk("single mem_addr", 32'(mem_addr), 32'h0000010);
                    chk("single mem_din", 32'(mem_din), 32'hA5);
                end
                nhigh++;
            end
        end
        chk("single latency", 32'(first), 32'd2);
        chk("single we length", 32'(nhigh), 32'd4);

        // Six back-to-back pushes: one launch frees a slot, the sixth is dropped
        align(2'd0);
        nw = 0; nhigh = 0;
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1; ld_addr = 22'h100 + 22'(i); ld_data = 8'h50 + 8'(i);
            tick();
            if (i == 4) chk("ready when full", 32'(ld_ready), 32'd0);
            if (mem_we) nhigh++;
            if (mem_we && last_ce == 2'd3 && nw < 8) begin
                got_addr[nw] = mem_addr[21:0]; got_data[nw] = mem_din; nw++;
            end
        end
        ld_valid = 1'b0;
        chk("overflow after drop", 32'(overflow), 32'd1);
        for (int k = 0; k < 28; k++) begin
            tick();
            if (mem_we) nhigh++;
            if (mem_we && last_ce == 2'd3 && nw < 8) begin
                got_addr[nw] = mem_addr[21:0]; got_data[nw] = mem_din; nw++;
            end
        end
        chk("burst writes", 32'(nw), 32'd5);
        chk("burst we cycles", 32'(nhigh), 32'd20);
        for (int i = 0; i < 5 && i < nw; i++) begin
            chk("burst addr order", 32'(got_addr[i]), 32'h100 + 32'(i));
            chk("burst data order", 32'(got_data[i]), 32'h50 + 32'(i));
        end

        // Three queued then load done: drain, exact hold-off, then CPU pass-through
        align(2'd0);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_addr = 22'h200 + 22'(i); ld_data = 8'h70 + 8'(i);
            tick();
        end
        ld_valid = 1'b0; ld_done = 1'b1;
        cpu_addr = 22'h012345; cpu_we = 1'b1; cpu_dout = 8'h3C; cpu_oe = 1'b0;
        nw = 0; t_fall = -1; t_rst = -1; prev_we = mem_we;
        for (int k = 0; k < 400 && t_rst < 0; k++) begin
            tick();
            if (nes_reset) begin
                if (mem_we && last_ce == 2'd3) nw++;
                if (prev_we && !mem_we) t_fall = k;
                prev_we = mem_we;
            end else begin
                t_rst = k;
                chk("run mem_addr", 32'(mem_addr), 32'h0012345);
                chk("run mem_we", 32'(mem_we), 32'd1);
                chk("run mem_din", 32'(mem_din), 32'h3C);
            end
        end
        chk("drain writes", 32'(nw), 32'd3);
        chk("nes_reset released", 32'(t_rst >= 0), 32'd1);
        chk("hold length", 32'(t_rst - t_fall), 32'(HOLD));

        // RUN mux vectors
        for (int i = 0; i < 4; i++) begin
            cpu_addr = tv[i].addr; cpu_we = tv[i].we; cpu_oe = tv[i].oe; cpu_dout = tv[i].dout;
            #1;
            chk("mux mem_addr", 32'(mem_addr), 32'(tv[i].e_addr));
            chk("mux mem_we", 32'(mem_we), 32'(tv[i].e_we));
            chk("mux mem_oe", 32'(mem_oe), 32'(tv[i].e_oe));
            chk("mux mem_din", 32'(mem_din), 32'(tv[i].e_din));
        end

        // New download from RUN
        cpu_oe = 1'b1; cpu_we = 1'b0; ld_done = 1'b0;
        tick();
        chk("redl nes_reset", 32'(nes_reset), 32'd1);
        chk("redl busy", 32'(busy), 32'd1);
        chk("redl mem_oe", 32'(mem_oe), 32'd0);
        chk("redl ld_ready", 32'(ld_ready), 32'd1);
        chk("overflow sticky", 32'(overflow), 32'd1);
        ld_valid = 1'b1; ld_addr = 22'h000300; ld_data = 8'h99;
        tick();
        ld_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 6 && seen == 0; k++) begin
            tick();
            if (mem_we) seen = 1;
        end
        chk("redl write seen", 32'(seen), 32'd1);
        chk("redl mem_addr", 32'(mem_addr), 32'h0000300);

        // R_reset mid-write with more bytes queued
        for (int i = 1; i < 3; i++) begin
            ld_valid = 1'b1; ld_addr = 22'h300 + 22'(i); ld_data = 8'h99;
            tick();
        end
        ld_valid = 1'b0;
        chk("we before reset", 32'(mem_we), 32'd1);
        R_reset = 1'b1;
        tick();
        R_reset = 1'b0;
        chk("reset drops we", 32'(mem_we), 32'd0);
        chk("reset clears overflow", 32'(overflow), 32'd0);
        nhigh = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (mem_we) nhigh++;
        end
        chk("no writes after reset", 32'(nhigh), 32'd0);

        // Random traffic against the model
        for (int seg = 0; seg < 6; seg++) begin
            int nload;
            nload = int'($urandom_range(120, 40));
            ld_done = 1'b0;
            for (int k = 0; k < nload; k++) begin
                ld_valid = ($urandom_range(2, 0) == 0);
                ld_addr  = 22'($urandom);
                ld_data  = 8'($urandom);
                cpu_addr = 22'($urandom); cpu_we = 1'($urandom); cpu_oe = 1'($urandom); cpu_dout = 8'($urandom);
                R_reset  = ($urandom_range(199, 0) == 0);
                tick();
            end
            R_reset = 1'b0; ld_done = 1'b1;
            for (int k = 0; k < 340; k++) begin
                ld_valid = ($urandom_range(7, 0) == 0);
                ld_addr  = 22'($urandom);
                ld_data  = 8'($urandom);
                cpu_addr = 22'($urandom); cpu_we = 1'($urandom); cpu_oe = 1'($urandom); cpu_dout = 8'($urandom);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_porta_arbiter.md
Name: sdram_porta_arbiter

Overview:
- Owns SDRAM port A (addrA/weA/dinA/oeA) and arbitrates it between the game loader and the NES CPU.
- During a download, loader byte writes go into a small FIFO. Each one is issued once per NES slot, aligned to nes_ce.
- After load_done, the FIFO drains, a reset hold-off runs, then port A passes straight through to the CPU.
- Replaces the ad-hoc loader_write_triggered / download_reset / mux logic in top.

Parameters:
- ADDR_W, 22, loader/CPU byte address width; mem_addr is ADDR_W+3 with 3'b000 prefix.
- FIFO_DEPTH, 4, loader write FIFO entries; power of two, >=2.
- SLOT_PHASE, 3, nes_ce value at which a queued write is launched.
- HOLD_CYCLES, 255, clock cycles nes_reset stays high after drain completes; 8-bit counter, 1..255.

Ports:
- clock  in  1  NES system clock.
- R_reset  in  1  synchronous, active-high reset.
- nes_ce  in  2  NES clock-enable phase counter.
- ld_valid  in  1  loader write strobe (single-cycle pulses).
- ld_addr  in  ADDR_W  loader byte address.
- ld_data  in  8  loader byte.
- ld_ready  out  1  FIFO can accept; = !full (registered count).
- ld_done  in  1  loader done level; falling edge = new download.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_we  in  1  CPU write.
- cpu_oe  in  1  CPU read.
- cpu_dout  in  8  CPU write data.
- mem_addr  out  ADDR_W+3  to sdram addrA.
- mem_we  out  1  to sdram weA.
- mem_oe  out  1  to sdram oeA.
- mem_din  out  8  to sdram dinA.
- nes_reset  out  1  hold NES in reset.
- overflow  out  1  sticky: a loader write was dropped.
- busy  out  1  high in any state except RUN.

Behaviour:
- Reset values (R_reset at clock edge):
  - state=LOAD, FIFO empty, write register cleared.
  - mem_we=0, nes_reset=1, overflow=0, busy=1, hold counter=HOLD_CYCLES.
- States:
  - LOAD: accept pushes; launch writes. ld_done=1 -> DRAIN.
  - DRAIN: no pushes accepted. FIFO empty and no write in flight -> HOLD.
  - HOLD: counter decrements each clock. At 0 -> RUN.
  - RUN: pass-through.
  - Any state: ld_done 1->0 edge (edge detector registered from reset value 1) -> LOAD. Clears FIFO and write register; nes_reset=1 the same cycle the edge is seen.
- Push:
  - ld_valid & !full in LOAD writes {addr,data}.
  - ld_valid & full: entry dropped, overflow<=1 (sticky until R_reset). Applies even if a pop happens that cycle.
- Launch: on a cycle with nes_ce==SLOT_PHASE, in LOAD or DRAIN:
  - FIFO non-empty: pop into the write register; mem_we<=1 next cycle.
  - FIFO empty: mem_we<=0.
  - mem_we, mem_addr and mem_din are held for a full 4-cycle nes_ce period, until the next slot cycle.
  - "In flight" = mem_we=1.
- Push and pop in the same cycle: both take effect; count unchanged.
- Mux:
  - RUN: mem_addr={3'b000,cpu_addr}, mem_we=cpu_we, mem_din=cpu_dout, mem_oe=cpu_oe (combinational).
  - Other states: registered loader values, mem_oe=0.
- nes_reset = (state!=RUN), registered. busy = (state!=RUN).
- Latency: push to mem_we rise is 1..4 clocks when the FIFO is empty. Throughput is 1 byte per 4 clocks.
- R_reset mid-write: mem_we drops the next cycle and the queued data is discarded.

Optional Feature:
- Macro: ARB_WRITE_COUNT_EN.
- With it: extra output wr_count [ADDR_W:0].
  - Counts loader writes launched since the last LOAD entry or reset.
  - Saturates at all-ones.
  - Frozen in HOLD and RUN, for ROM-size debug on the LEDs.
- Without it: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset, ld_done=0, idle -> mem_we=0, nes_reset=1, ld_ready=1, busy=1, overflow=0.
- One push {0x000010,0xA5} at nes_ce=1 -> mem_we=1 from the cycle after nes_ce==3, for exactly 4 clocks; mem_addr=0x0000010; mem_din=0xA5.
- Six back-to-back pushes, FIFO_DEPTH=4, one launch in between -> 5 accepted, 6th dropped; ld_ready=0 when full; overflow=1; 5 writes issued in order at 4-clock spacing.
- 3 entries queued, then ld_done=1 -> all 3 writes complete. nes_reset stays 1 for 255 clocks after the last mem_we fall, then 0; cpu_we/cpu_addr appear on mem_* the same cycle.
- In RUN, drop ld_done to 0 -> nes_reset=1 and busy=1 next edge; mem_oe=0; FIFO empty; new pushes accepted.
- R_reset pulse while mem_we=1 -> mem_we=0 next cycle; no further writes; overflow cleared.
